// File: rtl/iter_divider_pkg.sv
// rtl/iter_divider_pkg.sv - shared encodings and constants for the iterative RV32M divider
package iter_divider_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 5;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS_A,
    ST_ABS_B,
    ST_CALC,
    ST_NEG_Q,
    ST_NEG_R,
    ST_DONE
  } div_state_e;

endpackage

// File: rtl/carry_select_adder.sv
// rtl/carry_select_adder.sv - carry-select adder built from ripple blocks with precomputed carry-in 0/1 sums
module carry_select_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int NB = WIDTH / BLOCK;

  logic [NB:0] carry;

  assign carry[0] = cin_i;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [BLOCK:0] s0;
    logic [BLOCK:0] s1;

    // Both candidate sums are ready before the block's carry-in settles.
    assign s0 = {1'b0, a_i[g*BLOCK +: BLOCK]} + {1'b0, b_i[g*BLOCK +: BLOCK]};
    assign s1 = {1'b0, a_i[g*BLOCK +: BLOCK]} + {1'b0, b_i[g*BLOCK +: BLOCK]} + (BLOCK+1)'(1);

    assign sum_o[g*BLOCK +: BLOCK] = carry[g] ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
    assign carry[g+1]              = carry[g] ? s1[BLOCK]     : s0[BLOCK];
  end

  assign cout_o = carry[NB];

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle restoring divider for DIV/DIVU/REM/REMU sharing one adder
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit EARLY_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  div_state_e      state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] q_q;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic            negq_q;
  logic            negr_q;
  logic            out_valid_q;

  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_b;
  logic            add_cin;
  logic [XLEN-1:0] add_sum;
  logic            add_cout;

  logic            signed_op;
  logic            is_rem;
  logic [XLEN-1:0] rs_d;
  logic            ok_d;
  logic            in_signed;
  logic            div_zero;
  logic            ovf;

  assign signed_op = (op_q == OP_DIV) || (op_q == OP_REM);
  assign is_rem    = op_q[1];
  assign rs_d      = {r_q[XLEN-2:0], q_q[XLEN-1]};
  // The bit shifted out of r is the 33rd bit of the trial compare.
  assign ok_d      = r_q[XLEN-1] | add_cout;

  assign in_signed = ~op[0];
  assign div_zero  = (divisor == '0);
  assign ovf       = in_signed && (dividend == INT_MIN) && (divisor == ALL_ONES);

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      ST_ABS_A: begin add_a = ~q_q; add_cin = 1'b1; end
      ST_ABS_B: begin add_a = ~b_q; add_cin = 1'b1; end
      ST_CALC:  begin add_a = rs_d; add_b = ~b_q; add_cin = 1'b1; end
      ST_NEG_Q: begin add_a = ~q_q; add_cin = 1'b1; end
      ST_NEG_R: begin add_a = ~r_q; add_cin = 1'b1; end
      default:  ;
    endcase
  end

  carry_select_adder #(
    .WIDTH (XLEN),
    .BLOCK (4)
  ) u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      q_q         <= '0;
      r_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            q_q    <= dividend;
            b_q    <= divisor;
            r_q    <= '0;
            cnt_q  <= '0;
            // Divide-by-zero must yield all ones even when the full iteration runs.
            negq_q <= in_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]) & ~div_zero;
            negr_q <= in_signed & dividend[XLEN-1];
            if (EARLY_SPECIAL && (div_zero || ovf)) begin
              result_q    <= div_zero ? (op[1] ? dividend : ALL_ONES)
                                      : (op[1] ? '0 : INT_MIN);
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_ABS_A;
            end
          end
        end
        ST_ABS_A: begin
          if (signed_op && q_q[XLEN-1]) q_q <= add_sum;
          state_q <= ST_ABS_B;
        end
        ST_ABS_B: begin
          if (signed_op && b_q[XLEN-1]) b_q <= add_sum;
          state_q <= ST_CALC;
        end
        ST_CALC: begin
          r_q   <= ok_d ? add_sum : rs_d;
          q_q   <= {q_q[XLEN-2:0], ok_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= ST_NEG_Q;
        end
        ST_NEG_Q: begin
          if (negq_q) q_q <= add_sum;
          state_q <= ST_NEG_R;
        end
        ST_NEG_R: begin
          result_q    <= is_rem ? (negr_q ? add_sum : r_q) : q_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
